// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// XLEN_DEF / AW_DEF are the default data and address widths; rf_wr_t
// bundles one register-file write (destination + data).
package rf_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned AW_DEF       = 5;
  // Width of the B starvation counter; STARVE_LIMIT must fit (1..15).
  localparam int unsigned STARVE_CNT_W = 4;

  typedef logic [AW_DEF-1:0]   rf_addr_t;
  typedef logic [XLEN_DEF-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t wd;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_starve_cnt.sv
// Saturating starvation counter for writeback requester B.
// Counts consecutive cycles in which B is valid but not granted, saturating
// at STARVE_LIMIT (1..15). Clears on a B grant or when B is idle.
// Ports:
//   i_clk      rising-edge clock
//   i_rst      synchronous reset, active-high
//   i_b_valid  B has a write pending
//   i_b_grant  B accepted this cycle
//   o_starved  counter at limit; B has forced priority
module rf_wb_starve_cnt
  import rf_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_b_valid,
  input  logic i_b_grant,
  output logic o_starved
);

  localparam logic [STARVE_CNT_W-1:0] Limit = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_cnt;
  logic [STARVE_CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_b_valid || i_b_grant) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != Limit) begin
      w_cnt_nxt = r_cnt + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_starved = (r_cnt == Limit);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for two writeback requesters.
// A (load unit) has fixed priority over B (ALU/branch) unless B has been
// starved for STARVE_LIMIT consecutive cycles. The winner is registered into
// a single output stage driving rf_we/rf_rd/rf_wd one cycle later. Writes to
// x0 are acknowledged but never reach the register file.
// Ports:
//   clk, rst_n                 clock; synchronous reset, active-high
//   a_valid/a_ready/a_rd/a_wd  requester A handshake and payload
//   b_valid/b_ready/b_rd/b_wd  requester B handshake and payload
//   rf_we/rf_rd/rf_wd          register-file write port
//   starved                    B currently has forced priority
// Optional feature (macro RF_WB_FWD_EN): fwd_rs1/fwd_rs2 inputs and
// fwd_hit1/2, fwd_data1/2 outputs that bypass the in-flight write.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_wd,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_wd,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic            starved
`ifdef RF_WB_FWD_EN
  ,
  input  logic [AW-1:0]   fwd_rs1,
  input  logic [AW-1:0]   fwd_rs2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2
`endif
);

  // rst_n is active-high despite its name.
  logic            w_rst;
  logic            w_starved;
  logic            w_a_grant;
  logic            w_b_grant;
  logic            w_grant;
  logic            w_wr_en;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_wd;

  logic            r_we;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_wd;

  assign w_rst = rst_n;

  rf_wb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .i_clk     (clk),
    .i_rst     (w_rst),
    .i_b_valid (b_valid),
    .i_b_grant (w_b_grant),
    .o_starved (w_starved)
  );

  // A wins unless B is starved; a lone requester always wins.
  always_comb begin
    w_a_grant = 1'b0;
    w_b_grant = 1'b0;
    if (!w_rst) begin
      w_a_grant = a_valid & (~b_valid | ~w_starved);
      w_b_grant = b_valid & (~a_valid | w_starved);
    end
  end

  assign w_grant  = w_a_grant | w_b_grant;
  assign w_sel_rd = w_b_grant ? b_rd : a_rd;
  assign w_sel_wd = w_b_grant ? b_wd : a_wd;
  // x0 grants complete the handshake but are not written.
  assign w_wr_en  = w_grant & (w_sel_rd != '0);

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_wr_en;
      if (w_wr_en) begin
        r_rd <= w_sel_rd;
        r_wd <= w_sel_wd;
      end
    end
  end

  assign a_ready = w_a_grant;
  assign b_ready = w_b_grant;
  assign rf_we   = r_we;
  assign rf_rd   = r_rd;
  assign rf_wd   = r_wd;
  assign starved = w_starved;

`ifdef RF_WB_FWD_EN
  // Same-cycle bypass of the write currently presented to the register file.
  assign fwd_hit1  = r_we & (r_rd == fwd_rs1) & (fwd_rs1 != '0);
  assign fwd_hit2  = r_we & (r_rd == fwd_rs2) & (fwd_rs2 != '0);
  assign fwd_data1 = r_wd;
  assign fwd_data2 = r_wd;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a driver applies directed then random
// requests, predicts handshakes from the arbitration rules and queues the
// expected register-file write; a monitor pops and checks after each edge.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int Limit = 4;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, rf_rd;
  logic [31:0] a_wd, b_wd, rf_wd;
  logic        rf_we;
  logic        starved;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  rf_wb_arbiter #(
    .XLEN         (32),
    .AW           (5),
    .STARVE_LIMIT (Limit)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_wd      (a_wd),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_wd      (b_wd),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .starved   (starved)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_rs1   (fwd_rs1),
    .fwd_rs2   (fwd_rs2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic   we;
    logic   zero;  // reset cycle: rd/wd must also be cleared
    rf_wr_t wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_denied = 0;  // model: consecutive cycles B has been refused
  bit   done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; returns the grants predicted by the model.
  task automatic step(input logic rst, input logic av, input logic [4:0] ar,
                      input logic [31:0] ad, input logic bv, input logic [4:0] br,
                      input logic [31:0] bd, output logic ag, output logic bg);
    exp_t e;
    bit   sv;
    @(negedge clk);
    rst_n = rst; a_valid = av; a_rd = ar; a_wd = ad;
    b_valid = bv; b_rd = br; b_wd = bd;
    #1;
    sv = (m_denied == Limit);
    ag = 1'b0;
    bg = 1'b0;
    if (!rst) begin
      case ({av, bv})
        2'b10:   ag = 1'b1;
        2'b01:   bg = 1'b1;
        2'b11:   if (sv) bg = 1'b1; else ag = 1'b1;
        default: ;
      endcase
    end
    chk("a_ready", {31'b0, a_ready}, {31'b0, ag});
    chk("b_ready", {31'b0, b_ready}, {31'b0, bg});
    chk("starved", {31'b0, starved}, {31'b0, sv});
    e.zero  = rst;
    e.we    = 1'b0;
    e.wr.rd = '0;
    e.wr.wd = '0;
    if (ag && ar != 0) begin e.we = 1'b1; e.wr.rd = ar; e.wr.wd = ad; end
    if (bg && br != 0) begin e.we = 1'b1; e.wr.rd = br; e.wr.wd = bd; end
    exp_q.push_back(e);
    if (rst || !bv || bg) m_denied = 0;
    else if (m_denied < Limit) m_denied++;
  endtask

  // Monitor: one expectation per cycle, checked just after the edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_we", {31'b0, rf_we}, {31'b0, e.we});
        if (e.zero) begin
          chk("rf_rd_rst", {27'b0, rf_rd}, 32'h0);
          chk("rf_wd_rst", rf_wd, 32'h0);
        end
        if (e.we) begin
          chk("rf_rd", {27'b0, rf_rd}, {27'b0, e.wr.rd});
          chk("rf_wd", rf_wd, e.wr.wd);
        end
`ifdef RF_WB_FWD_EN
        chk("fwd_hit1", {31'b0, fwd_hit1},
            {31'b0, e.we && e.wr.rd == fwd_rs1 && fwd_rs1 != 0});
        chk("fwd_hit2", {31'b0, fwd_hit2},
            {31'b0, e.we && e.wr.rd == fwd_rs2 && fwd_rs2 != 0});
        if (e.we) begin
          chk("fwd_data1", fwd_data1, e.wr.wd);
          chk("fwd_data2", fwd_data2, e.wr.wd);
        end
`endif
      end
    end
  end

  initial begin
    logic        ag, bg;
    logic        a_pend, b_pend;
    logic [4:0]  pa_rd, pb_rd;
    logic [31:0] pa_wd, pb_wd;
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; a_wd = '0; b_rd = '0; b_wd = '0;
`ifdef RF_WB_FWD_EN
    fwd_rs1 = '0; fwd_rs2 = '0;
`endif

    // Reset held with both requesters valid.
    step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, ag, bg);
    step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, ag, bg);

    // Single A write, then idle.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, ag, bg);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);

    // Priority: A first, B once A drops.
    step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, ag, bg);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h22, ag, bg);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);

    // Starvation: A always valid, B held until granted, then one more cycle.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 5'(10 + i), 32'(i), 1'b1, 5'd9, 32'h99, ag, bg);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);

    // x0 write by B is acknowledged but not performed.
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, ag, bg);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);

    // Mid-operation reset drops the pending write.
    step(1'b0, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0, ag, bg);
    step(1'b1, 1'b1, 5'd8, 32'h66, 1'b0, 5'd0, 32'h0, ag, bg);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);

`ifdef RF_WB_FWD_EN
    // Forwarding hit on rd=7, then rs=0 never hits.
    step(1'b0, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'h0, ag, bg);
    fwd_rs1 = 5'd7;
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);
    fwd_rs1 = 5'd0;
    step(1'b0, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0, ag, bg);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);
`endif

    // Random traffic; requesters hold payload until accepted.
    a_pend = 1'b0; b_pend = 1'b0;
    pa_rd = '0; pb_rd = '0; pa_wd = '0; pb_wd = '0;
    for (int i = 0; i < 600; i++) begin
      logic rst;
      if (!a_pend && ($urandom % 10) < 6) begin
        a_pend = 1'b1;
        pa_rd  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
        pa_wd  = $urandom;
      end
      if (!b_pend && ($urandom % 10) < 7) begin
        b_pend = 1'b1;
        pb_rd  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
        pb_wd  = $urandom;
      end
`ifdef RF_WB_FWD_EN
      fwd_rs1 = (($urandom % 2) == 0) ? pa_rd : 5'($urandom);
      fwd_rs2 = (($urandom % 2) == 0) ? pb_rd : 5'($urandom);
`endif
      rst = (($urandom % 60) == 0);
      step(rst, a_pend, pa_rd, pa_wd, b_pend, pb_rd, pb_wd, ag, bg);
      if (ag) a_pend = 1'b0;
      if (bg) b_pend = 1'b0;
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ag, bg);

    repeat (3) @(posedge clk);
    #3;
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters. Requester A is the load unit; requester B is the ALU/branch writeback. Grants at most one write per cycle through a valid/ready handshake and registers the winner into a one-stage output pipeline that drives the register file's we/rd/wd. Fixed priority goes to A, with a starvation counter that guarantees B forward progress.

Parameters:
XLEN, 32, data width of write data
AW, 5, register address width (2^AW registers)
STARVE_LIMIT, 4, consecutive cycles B may be denied before B is forced to win; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-high (asserted = 1 resets)
a_valid  in  1  A has a write pending
a_ready  out  1  A write accepted this cycle
a_rd  in  AW  A destination register
a_wd  in  XLEN  A write data
b_valid  in  1  B has a write pending
b_ready  out  1  B write accepted this cycle
b_rd  in  AW  B destination register
b_wd  in  XLEN  B write data
rf_we  out  1  register-file write enable
rf_rd  out  AW  register-file write address
rf_wd  out  XLEN  register-file write data
starved  out  1  B starvation counter at limit; B has forced priority

Behaviour:
- Reset (rst_n=1 at posedge):
  - rf_we=0, rf_rd=0, rf_wd=0.
  - Starvation count=0, starved=0.
  - a_ready=b_ready=0 while rst_n=1.
- Handshake: a transfer occurs on x_valid & x_ready. ready is combinational from valid and the current starvation state. A requester holds valid and its payload stable until accepted.
- Arbitration, each cycle, exactly one of:
  - only A valid: grant A.
  - only B valid: grant B.
  - both valid and starved=0: grant A.
  - both valid and starved=1: grant B.
  - neither valid: no grant.
- Starvation counter (width 4):
  - Increments when b_valid & !b_ready, saturating at STARVE_LIMIT.
  - Clears to 0 on any B grant, or when b_valid=0.
  - starved = (count == STARVE_LIMIT).
- Output stage, registered, 1-cycle latency: on a grant at edge N, rf_we/rf_rd/rf_wd show the granted payload after edge N. With no grant, rf_we=0 and rf_rd/rf_wd hold their previous values.
- x0 rule: a grant with rd==0 is still acknowledged (ready=1) but produces rf_we=0. It counts as a grant for the starvation logic.
- Throughput: one write per cycle sustained. The register file always accepts, so there is no output backpressure.
- Simultaneous same-rd requests: only the winner is written; the loser retries on a later cycle and therefore lands last.
- Reset mid-operation: any pending output write is dropped (rf_we=0 next cycle). Requesters must re-present their writes.

Optional Feature:
Macro RF_WB_FWD_EN.
- Defined: adds inputs fwd_rs1, fwd_rs2 (AW) and outputs fwd_hit1, fwd_hit2 (1) and fwd_data1, fwd_data2 (XLEN).
  - fwd_hitK = rf_we & (rf_rd == fwd_rsK) & (fwd_rsK != 0). Combinational.
  - fwd_dataK = rf_wd.
  - Purpose: bypass the register file's same-cycle write/read.
- Undefined: these ports do not exist and no comparators are built.

Decomposition:
- Package rf_pkg holds XLEN_DEF=32, AW_DEF=5, typedef rf_addr_t and rf_data_t, and struct rf_wr_t {rd, wd}.
- One natural sub-module, rf_wb_starve_cnt: the saturating counter plus the starved flag.
- Arbitration mux and output register stay in the top module.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_we=0, starved=0 throughout.
- Single write: A-only, a_rd=5, a_wd=0xDEADBEEF -> a_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
- Priority: both valid, A rd=3/0x11, B rd=4/0x22 -> A granted first; B granted on the next cycle once A drops valid; rf writes 3 then 4 on consecutive cycles.
- Starvation: A valid every cycle, B valid continuously, STARVE_LIMIT=4 -> B denied for 4 cycles, starved=1 on the 5th cycle, B granted that cycle, counter back to 0 the next cycle.
- x0 drop: B-only with b_rd=0, b_wd=0xFFFFFFFF -> b_ready=1; rf_we stays 0 the next cycle.
- Mid-op reset and forwarding (RF_WB_FWD_EN defined):
  - A granted rd=7/0x55, then reset on the following edge -> rf_we=0 after that edge.
  - Without reset, fwd_rs1=7 during the output cycle -> fwd_hit1=1, fwd_data1=0x55.
  - fwd_rs1=0 -> fwd_hit1=0.
